// File: rtl/rr_select_arbiter_pkg.sv
// Shared types and sizes for the round-robin select arbiter.
package rr_select_arbiter_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StGrant   = 2'b01,
    StRelease = 2'b10
  } state_e;

endpackage

// File: rtl/rr_select_arbiter_pick.sv
// Combinational rotating-priority picker: first requester above last_sel, wrapping 3 -> 0.
module rr_pick
  import rr_select_arbiter_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last_sel,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Walk from the farthest candidate down to the nearest so the nearest wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = |req;
    for (int k = N_CH; k >= 1; k--) begin
      idx = last_sel + SEL_W'(k);
      if (req[idx]) begin
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin 4-channel arbiter driving a registered decoder select, with hold timeout.
module rr_select_arbiter
  import rr_select_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] select,
  output logic             grant_valid,
  output logic             timeout_pulse
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             tpulse_q, tpulse_d;

  logic [SEL_W-1:0] pick;
  logic             any;
  logic             normal_rel;
  logic             expired;

  rr_pick u_pick (
    .req      (req),
    .last_sel (last_q),
    .pick     (pick),
    .any      (any)
  );

  assign normal_rel = done | ~req[sel_q];
  assign expired    = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    tpulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          state_d = StGrant;
          sel_d   = pick;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (normal_rel || expired) begin
          state_d  = StRelease;
          valid_d  = 1'b0;
          last_d   = sel_q;
          // A simultaneous normal release takes precedence over the timeout.
          tpulse_d = expired & ~normal_rel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      last_q   <= SEL_W'(N_CH - 1);
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      tpulse_q <= tpulse_d;
    end
  end

  assign select        = sel_q;
  assign grant_valid   = valid_q;
  assign timeout_pulse = tpulse_q;

endmodule
